divide_reconstruct: RTL and testbench
=====================================

DIVIDE_RECONSTRUCT -- requirements
Module: divide_reconstruct

Interface
REQ-001 Parameter: WIDTH, 4, operand width; Result is 2*WIDTH bits.
REQ-002 Clock  input  1  rising-edge clock; the block uses this single clock only.
REQ-003 Resetn  input  1  synchronous, active-low reset.
REQ-004 Go  input  1  start request, level-sampled.
REQ-005 Quotient  input  WIDTH  quotient operand.
REQ-006 Divisor  input  WIDTH  divisor operand.
REQ-007 Remainder  input  WIDTH  remainder operand.
REQ-008 Result  output  2*WIDTH  registered Quotient*Divisor+Remainder.
REQ-009 Done  output  1  high while Result holds a completed value for the current request.
REQ-010 Error  output  1  remainder-check flag; see Configuration.

Function
REQ-011 The block SHALL compute Result = Quotient*Divisor + Remainder, unsigned, by sequential shift-and-add, with no multiplier operator.
REQ-012 FSM states SHALL be IDLE, LOAD, ADD, SHIFT and DONE.
REQ-013 IDLE->LOAD SHALL occur on an edge with Go=1; otherwise the FSM stays in IDLE.
REQ-014 LOAD SHALL register the operands in one cycle:
- ACC = zero-extended Remainder
- M = zero-extended Divisor
- Q = Quotient
- counter = WIDTH
- then go to ADD.
REQ-015 ADD SHALL set ACC = ACC + M when Q[0]=1, leave ACC unchanged otherwise, then go to SHIFT.
REQ-016 SHIFT SHALL do M<<1, Q>>1 and counter-1; it goes to ADD if the decremented counter is nonzero, else to DONE.
REQ-017 Result SHALL load ACC on the edge entering DONE; Done SHALL be high exactly while in DONE.
REQ-018 Latency: Done SHALL first be high 2*WIDTH+2 cycles after the edge sampling Go (10 for WIDTH=4).
REQ-019 DONE SHALL hold while Go=1 and return to IDLE on the first edge with Go=0, so a held Go yields exactly one operation.
REQ-020 Go and operand changes outside IDLE/LOAD SHALL have no effect on the operation in progress.
REQ-021 ACC SHALL be 2*WIDTH bits; no overflow is possible because (2^W-1)^2+(2^W-1) < 2^(2W).
REQ-022 Result SHALL retain its last value in IDLE until the next DONE entry.

Reset
REQ-023 With Resetn=0 at an edge, the FSM SHALL go to IDLE and Result, Done, Error, ACC, M, Q and counter SHALL clear to 0.
REQ-024 Reset SHALL take priority over all other activity, including mid-operation; the next request after reset SHALL compute normally.

Configuration
REQ-025 Macro DIVIDE_RECONSTRUCT_RCHECK_EN is the single compile-time option.
REQ-026 When defined, LOAD SHALL register Error = (Remainder >= Divisor), marking an invalid divider triple.
REQ-027 When defined, Error SHALL hold until the next LOAD or reset; Result SHALL still be computed.
REQ-028 When not defined, Error SHALL be tied to 0 and no comparator logic SHALL be generated.

Structure
REQ-029 A shared package SHALL hold the state-encoding constants (IDLE..DONE, 3-bit) and the WIDTH default.
REQ-030 Control FSM and datapath SHALL be split; the datapath (ACC, M, Q, counter, adder) SHALL be sub-module reconstruct_datapath.

Verification
REQ-031 Q=3, D=5, R=2, Go pulse -> Result=17 (0x11), Done high at cycle 10.
REQ-032 Q=15, D=15, R=14 -> Result=239 (0xEF); Q=0, D=0, R=0 -> Result=0, Done still asserts at cycle 10.
REQ-033 Go held high 30 cycles, Q=6, D=7, R=1 -> one operation, Result=43, Done stays high until Go falls, then IDLE.
REQ-034 Operands changed to Q=1, D=1, R=0 during ADD/SHIFT of Q=4, D=3, R=2 -> Result=14.
REQ-035 Resetn=0 for one edge in the 5th cycle after Go -> Result=0, Done=0, IDLE; a new Go with Q=2, D=2, R=1 -> Result=5.
REQ-036 With DIVIDE_RECONSTRUCT_RCHECK_EN defined, Q=3, D=5, R=7 -> Error=1, Result=22; Q=3, D=5, R=4 -> Error=0, Result=19.

Source files
------------

// File: rtl/divide_reconstruct_pkg.sv
// Shared constants for the divide_reconstruct block: FSM state encoding and default operand width.
package divide_reconstruct_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/divide_reconstruct_if.sv
// Request/result bundle for divide_reconstruct: operands and go in, result/done/error out.
interface divide_reconstruct_if #(
  parameter int unsigned WIDTH = divide_reconstruct_pkg::DEFAULT_WIDTH
);
  logic               go;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   remainder;
  logic [2*WIDTH-1:0] result;
  logic               done;
  logic               error;

  modport master (
    output go, quotient, divisor, remainder,
    input  result, done, error
  );

  modport slave (
    input  go, quotient, divisor, remainder,
    output result, done, error
  );
endinterface

// File: rtl/reconstruct_datapath.sv
// Shift-and-add datapath: ACC accumulates M (shifted divisor) for each set bit of Q.
module reconstruct_datapath #(
  parameter int unsigned WIDTH = divide_reconstruct_pkg::DEFAULT_WIDTH
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               load_en,
  input  logic               add_en,
  input  logic               shift_en,
  input  logic [WIDTH-1:0]   quotient,
  input  logic [WIDTH-1:0]   divisor,
  input  logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] m;
  logic [WIDTH-1:0]   q;
  logic [CW-1:0]      counter;

  // last flags the SHIFT whose decrement reaches zero
  assign last = (counter == CW'(1));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      acc     <= '0;
      m       <= '0;
      q       <= '0;
      counter <= '0;
    end else if (load_en) begin
      acc     <= {{WIDTH{1'b0}}, remainder};
      m       <= {{WIDTH{1'b0}}, divisor};
      q       <= quotient;
      counter <= CW'(WIDTH);
    end else if (add_en) begin
      if (q[0]) acc <= acc + m;
    end else if (shift_en) begin
      m       <= m << 1;
      q       <= q >> 1;
      counter <= counter - CW'(1);
    end
  end
endmodule

// File: rtl/divide_reconstruct.sv
// Reconstructs Quotient*Divisor+Remainder sequentially; control FSM here, arithmetic in reconstruct_datapath.
// Optional macro DIVIDE_RECONSTRUCT_RCHECK_EN enables the Remainder >= Divisor error flag.
module divide_reconstruct
  import divide_reconstruct_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic                clock,
  input logic                resetn,
  divide_reconstruct_if.slave bus
);
  state_t             state;
  logic [2*WIDTH-1:0] result;
  logic               done;
  logic               error;
  logic [2*WIDTH-1:0] acc;
  logic               last;
  logic               load_en;
  logic               add_en;
  logic               shift_en;

  assign load_en  = (state == LOAD);
  assign add_en   = (state == ADD);
  assign shift_en = (state == SHIFT);

  reconstruct_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock     (clock),
    .resetn    (resetn),
    .load_en   (load_en),
    .add_en    (add_en),
    .shift_en  (shift_en),
    .quotient  (bus.quotient),
    .divisor   (bus.divisor),
    .remainder (bus.remainder),
    .acc       (acc),
    .last      (last)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state  <= IDLE;
      result <= '0;
      done   <= 1'b0;
`ifdef DIVIDE_RECONSTRUCT_RCHECK_EN
      error  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:  if (bus.go) state <= LOAD;
        LOAD: begin
`ifdef DIVIDE_RECONSTRUCT_RCHECK_EN
          error <= (bus.remainder >= bus.divisor);
`endif
          state <= ADD;
        end
        ADD:   state <= SHIFT;
        SHIFT: begin
          if (last) begin
            state  <= DONE;
            result <= acc;
            done   <= 1'b1;
          end else begin
            state <= ADD;
          end
        end
        DONE: begin
          if (!bus.go) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifndef DIVIDE_RECONSTRUCT_RCHECK_EN
  assign error = 1'b0;
`endif

  assign bus.result = result;
  assign bus.done   = done;
  assign bus.error  = error;
endmodule

// File: tb/tb_divide_reconstruct.sv
// Self-checking bench for divide_reconstruct: directed and random operand triples against an arithmetic model.
module tb_divide_reconstruct;
  localparam int unsigned W   = 4;
  localparam int          LAT = 2 * W + 2;

  logic clock;
  logic resetn;
  int   vectors;
  int   miscompares;

  divide_reconstruct_if #(.WIDTH(W)) bus ();

  divide_reconstruct #(.WIDTH(W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [2*W-1:0] model_result(input int q, input int d, input int r);
    return (2*W)'(q * d + r);
  endfunction

  function automatic logic model_error(input int d, input int r);
`ifdef DIVIDE_RECONSTRUCT_RCHECK_EN
    return (r >= d);
`else
    return 1'b0;
`endif
  endfunction

  // Pulses go for one edge; lat counts edges with the go-sampling edge as 1 (-1 on timeout).
  task automatic do_op(input logic [W-1:0] q, d, r, output int lat);
    @(negedge clock);
    bus.go = 1'b1; bus.quotient = q; bus.divisor = d; bus.remainder = r;
    @(negedge clock);
    bus.go = 1'b0;
    lat = 1;
    while (!bus.done && lat < 60) begin
      @(negedge clock);
      lat++;
    end
    if (!bus.done) lat = -1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    resetn = 1'b0; bus.go = 1'b0;
    bus.quotient = '0; bus.divisor = '0; bus.remainder = '0;
    repeat (2) @(negedge clock);
    vectors++;
    if (bus.result !== 8'h00 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: result=%h done=%b error=%b, required 00/0/0", bus.result, bus.done, bus.error);
    end
    resetn = 1'b1;
  endtask

  task automatic test_directed();
    int tq[4] = '{3, 15, 0, 3};
    int td[4] = '{5, 15, 0, 5};
    int tr[4] = '{2, 14, 0, 7};
    int lat;
    logic [2*W-1:0] exp_res;
    for (int i = 0; i < 4; i++) begin
      exp_res = model_result(tq[i], td[i], tr[i]);
      do_op(W'(tq[i]), W'(td[i]), W'(tr[i]), lat);
      vectors++;
      if (lat !== LAT || bus.result !== exp_res || bus.error !== model_error(td[i], tr[i])) begin
        miscompares++;
        $display("FAIL directed[%0d]: lat=%0d result=%h error=%b, required lat=%0d result=%h error=%b",
                 i, lat, bus.result, bus.error, LAT, exp_res, model_error(td[i], tr[i]));
      end
      repeat (3) @(negedge clock);
      vectors++;
      if (bus.done !== 1'b0 || bus.result !== exp_res) begin
        miscompares++;
        $display("FAIL retain[%0d]: done=%b result=%h, required 0/%h", i, bus.done, bus.result, exp_res);
      end
    end
  endtask

  task automatic test_random();
    int q, d, r, lat;
    for (int i = 0; i < 20; i++) begin
      q = int'($urandom_range(0, 15));
      d = int'($urandom_range(0, 15));
      r = int'($urandom_range(0, 15));
      do_op(W'(q), W'(d), W'(r), lat);
      vectors++;
      if (lat !== LAT || bus.result !== model_result(q, d, r) || bus.error !== model_error(d, r)) begin
        miscompares++;
        $display("FAIL random %0d*%0d+%0d: lat=%0d result=%h error=%b, required lat=%0d result=%h error=%b",
                 q, d, r, lat, bus.result, bus.error, LAT, model_result(q, d, r), model_error(d, r));
      end
      @(negedge clock);
    end
  endtask

  task automatic test_held_go();
    int first_done = -1;
    int drops = 0;
    @(negedge clock);
    bus.go = 1'b1; bus.quotient = 4'd6; bus.divisor = 4'd7; bus.remainder = 4'd1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (bus.done && first_done < 0) first_done = c;
      if (!bus.done && first_done >= 0) drops++;
    end
    vectors++;
    if (first_done !== LAT || drops !== 0 || bus.result !== 8'd43) begin
      miscompares++;
      $display("FAIL held_go: first_done=%0d drops=%0d result=%0d, required %0d/0/43",
               first_done, drops, bus.result, LAT);
    end
    bus.go = 1'b0;
    @(negedge clock);
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL held_go_release: done=%b, required 0", bus.done);
    end
    repeat (15) @(negedge clock);
    vectors++;
    if (bus.done !== 1'b0 || bus.result !== 8'd43) begin
      miscompares++;
      $display("FAIL held_go_single: done=%b result=%0d, required 0/43", bus.done, bus.result);
    end
  endtask

  task automatic test_operand_change();
    int lat = 1;
    @(negedge clock);
    bus.go = 1'b1; bus.quotient = 4'd4; bus.divisor = 4'd3; bus.remainder = 4'd2;
    @(negedge clock);
    bus.go = 1'b0;
    @(negedge clock);
    lat++;
    // operands now registered; scramble them and pulse go mid-operation
    bus.quotient = 4'd1; bus.divisor = 4'd1; bus.remainder = 4'd0; bus.go = 1'b1;
    @(negedge clock);
    lat++;
    bus.go = 1'b0;
    while (!bus.done && lat < 60) begin
      @(negedge clock);
      lat++;
    end
    vectors++;
    if (lat !== LAT || bus.result !== model_result(4, 3, 2)) begin
      miscompares++;
      $display("FAIL operand_change: lat=%0d result=%0d, required %0d/%0d", lat, bus.result, LAT, model_result(4, 3, 2));
    end
    @(negedge clock);
  endtask

  task automatic test_mid_reset();
    int lat;
    int seen_done = 0;
    @(negedge clock);
    bus.go = 1'b1; bus.quotient = 4'd9; bus.divisor = 4'd9; bus.remainder = 4'd9;
    @(negedge clock);
    bus.go = 1'b0;
    repeat (4) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    vectors++;
    if (bus.result !== 8'h00 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: result=%h done=%b error=%b, required 00/0/0", bus.result, bus.done, bus.error);
    end
    repeat (15) begin
      @(negedge clock);
      if (bus.done) seen_done++;
    end
    vectors++;
    if (seen_done !== 0) begin
      miscompares++;
      $display("FAIL mid_reset_idle: done cycles=%0d, required 0", seen_done);
    end
    do_op(4'd2, 4'd2, 4'd1, lat);
    vectors++;
    if (lat !== LAT || bus.result !== 8'd5 || bus.error !== model_error(2, 1)) begin
      miscompares++;
      $display("FAIL after_reset: lat=%0d result=%0d error=%b, required %0d/5/%b",
               lat, bus.result, bus.error, LAT, model_error(2, 1));
    end
    @(negedge clock);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    resetn = 1'b0;
    bus.go = 1'b0;
    bus.quotient = '0; bus.divisor = '0; bus.remainder = '0;
    test_reset();
    test_directed();
    test_random();
    test_held_go();
    test_operand_change();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
